vga_framebuffer_fill_engine: RTL and testbench
==============================================

// Module: vga_framebuffer_fill_engine
// PURPOSE
//  Command-driven writer for the dual-port VGA framebuffer (640x480, 8-bit RRRGGGBB, linear addr y*640+x).
//  Accepts a rectangle command (origin, size, colour, mode), clips it to the screen and streams single-cycle
//  write requests (signal/address/data) into the framebuffer write port. Used for screen clear, boot patterns, test fills.
//  Its write clock is iVGA_CLK; the framebuffer write-clock input is tied to iVGA_CLK.
// PARAMETERS
//  VIDEO_W   640  visible width in pixels; row stride of the linear address
//  VIDEO_H   480  visible height in lines
//  WR_GAP    2    cycles between successive write-pulse starts, >=2. The write port ignores requests in the cycle after a write.
// PORTS
//  iVGA_CLK   in   1   clock, 25 MHz
//  iRST_n     in   1   asynchronous, active-low reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   engine idle; command accepted on a cycle with cmd_valid&cmd_ready
//  cmd_x      in   10  rectangle origin x
//  cmd_y      in   9   rectangle origin y
//  cmd_w      in   10  width in pixels
//  cmd_h      in   9   height in lines
//  cmd_color  in   8   base colour
//  cmd_mode   in   2   0=solid, 1=h-gradient, 2=8x8 checker, 3=reserved (treated as solid)
//  abort      in   1   stop the current command after any write already issued
//  busy       out  1   command in progress (not IDLE)
//  done       out  1   one-cycle pulse when a command finishes: normal completion, clip-to-nothing or abort
//  oFB_WR     out  1   framebuffer write strobe, one cycle wide
//  oFB_ADDR   out  19  framebuffer address
//  oFB_DATA   out  8   framebuffer pixel
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; state IDLE. Reset mid-command discards the command; no further writes.
//  All outputs are registered.
//  States:
//   IDLE
//    - cmd_ready=1.
//    - On accept, latch all cmd_* fields and go to SETUP.
//   SETUP (1 cycle)
//    - xe=min(x+w,VIDEO_W), ye=min(y+h,VIDEO_H), computed in 11/10 bits with no wrap.
//    - If w==0, h==0, x>=VIDEO_W or y>=VIDEO_H: go to DONE with no writes.
//    - Otherwise rowbase=y*VIDEO_W+x, computed as (y<<9)+(y<<7)+x in 19 bits; go to WRITE.
//   WRITE (1 cycle)
//    - Assert oFB_WR with the current oFB_ADDR and oFB_DATA.
//    - Advance x; at xe, move to the next row: rowbase+=VIDEO_W. There is no extra cycle for the row change.
//    - Go to GAP, or to DONE after the last pixel (at xe and ye-1).
//   GAP (WR_GAP-1 cycles)
//    - oFB_WR=0; then go to WRITE.
//   DONE
//    - done=1 for one cycle, then IDLE.
//    - After the last write, DONE is entered once its gap has elapsed.
//  Timing: accept at cycle 0.
//   - SETUP at cycle 1.
//   - k-th write (k=1..N) at cycle 1+k*WR_GAP-(WR_GAP-1), i.e. the first write at cycle 2.
//   - done at cycle 2+N*WR_GAP, where N=(xe-x)*(ye-y).
//   - Clip-to-nothing: done at cycle 2.
//  Pixel data, with xo/yo the offsets from the rectangle origin:
//   - solid: cmd_color.
//   - gradient: (cmd_color+xo[7:0]) mod 256.
//   - checker: (xo[3]^yo[3]) ? ~cmd_color : cmd_color.
//  Write order: row-major, ascending address; pixels never outside [0,VIDEO_W*VIDEO_H-1].
//  abort:
//   - Sampled in SETUP, WRITE or GAP.
//   - The next state is DONE and no further oFB_WR is issued; a write pulse on the abort cycle itself still completes.
//   - Ignored in IDLE and DONE.
//  Simultaneous events:
//   - cmd_valid while busy is not accepted and is held by the source.
//   - abort and cmd_valid together in IDLE: the command is accepted.
//  busy=1 in every state except IDLE; busy and done are both 1 in the DONE cycle.
// TESTING
//  - Full clear, x=0 y=0 w=640 h=480, colour 0xE0, solid:
//    307200 writes at addresses 0..0x4AFFF, ascending, spaced exactly 2 cycles; done at cycle 614402.
//  - Clip, x=638 y=10 w=5 h=2, colour 0x1F:
//    exactly 4 writes, at addresses 7038, 7039, 7678, 7679; done at cycle 10.
//  - Degenerate commands, w=0, then x=700:
//    no oFB_WR; done pulses at cycle 2; cmd_ready back to 1 at cycle 3.
//  - Checker, 16x16 at (0,0), colour 0x1C: data 0x1C at addr 0, 0xE3 at addr 8, 0xE3 at addr 5120, 0x1C at addr 5128.
//    Gradient, w=4, colour 0xFE: data FE, FF, 00, 01.
//  - Abort asserted in the cycle of the 3rd write:
//    exactly 3 writes, done in the next cycle, idle afterwards; a new command runs normally.
//  - iRST_n low mid-fill, then release:
//    oFB_WR=0, busy=0, done=0, cmd_ready=1 immediately; no writes until a new command is accepted.

Source files
------------

// File: rtl/vga_framebuffer_fill_engine.sv
// vga_framebuffer_fill_engine
//   Command-driven rectangle writer for the dual-port VGA framebuffer (8-bit RRRGGGBB pixels,
//   linear address y*VIDEO_W+x). A rectangle command is clipped to the screen and streamed as
//   single-cycle write requests into the framebuffer write port, which is clocked by iVGA_CLK.
//
// Ports
//   iVGA_CLK   in   clock
//   iRST_n     in   asynchronous, active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  engine idle; command accepted when cmd_valid & cmd_ready
//   cmd_x/y    in   rectangle origin
//   cmd_w/h    in   rectangle size
//   cmd_color  in   base colour
//   cmd_mode   in   0 solid, 1 horizontal gradient, 2 8x8 checker, 3 treated as solid
//   abort      in   stop the current command (a write already on the port still completes)
//   busy       out  command in progress
//   done       out  one-cycle pulse when a command finishes (normal, clipped away or aborted)
//   oFB_WR     out  framebuffer write strobe
//   oFB_ADDR   out  framebuffer address
//   oFB_DATA   out  framebuffer pixel
module vga_framebuffer_fill_engine #(
    parameter int unsigned VIDEO_W = 640,
    parameter int unsigned VIDEO_H = 480,
    parameter int unsigned WR_GAP  = 2
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic [9:0]  cmd_w,
    input  logic [8:0]  cmd_h,
    input  logic [7:0]  cmd_color,
    input  logic [1:0]  cmd_mode,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        oFB_WR,
    output logic [18:0] oFB_ADDR,
    output logic [7:0]  oFB_DATA
);

    // The gap counter holds WR_GAP-2 down to 0, i.e. WR_GAP-1 idle cycles after each write.
    localparam int unsigned   GW       = (WR_GAP > 2) ? $clog2(WR_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(WR_GAP - 2);
    localparam logic [18:0]   STRIDE   = 19'(VIDEO_W);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWrite,
        StGap,
        StDone
    } state_t;

    state_t        state_q;

    // Latched command
    logic [9:0]    x0_q;
    logic [8:0]    y0_q;
    logic [9:0]    w_q;
    logic [8:0]    h_q;
    logic [7:0]    color_q;
    logic [1:0]    mode_q;

    // Walk state: clipped extent, offsets of the next pixel, address of its row start
    logic [10:0]   xlen_q;
    logic [9:0]    ylen_q;
    logic [9:0]    xo_q;
    logic [8:0]    yo_q;
    logic [18:0]   rowbase_q;
    logic          last_q;
    logic [GW-1:0] gap_q;

    // Clipping, evaluated while in SETUP from the latched command
    logic [10:0]   xe_raw;
    logic [10:0]   xe_clip;
    logic [9:0]    ye_raw;
    logic [9:0]    ye_clip;
    logic          setup_empty;
    logic [18:0]   setup_rowbase;

    always_comb begin
        xe_raw        = {1'b0, x0_q} + {1'b0, w_q};
        xe_clip       = (xe_raw > 11'(VIDEO_W)) ? 11'(VIDEO_W) : xe_raw;
        ye_raw        = {1'b0, y0_q} + {1'b0, h_q};
        ye_clip       = (ye_raw > 10'(VIDEO_H)) ? 10'(VIDEO_H) : ye_raw;
        setup_empty   = (w_q == 10'd0) || (h_q == 9'd0) ||
                        ({1'b0, x0_q} >= 11'(VIDEO_W)) || ({1'b0, y0_q} >= 10'(VIDEO_H));
        setup_rowbase = 19'(y0_q) * STRIDE + 19'(x0_q);
    end

    // Pixel colour for offset (xo, yo) from the rectangle origin.
    function automatic logic [7:0] pix(input logic [1:0] mode, input logic [7:0] color,
                                       input logic [7:0] xo, input logic yo3);
        logic [7:0] p;
        unique case (mode)
            2'd1:    p = color + xo;
            2'd2:    p = (xo[3] ^ yo3) ? ~color : color;
            default: p = color;
        endcase
        return p;
    endfunction

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= StIdle;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            oFB_WR    <= 1'b0;
            oFB_ADDR  <= '0;
            oFB_DATA  <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            color_q   <= '0;
            mode_q    <= '0;
            xlen_q    <= '0;
            ylen_q    <= '0;
            xo_q      <= '0;
            yo_q      <= '0;
            rowbase_q <= '0;
            last_q    <= 1'b0;
            gap_q     <= '0;
        end else begin
            // Strobes default low; only the transitions below raise them for one cycle.
            oFB_WR <= 1'b0;
            done   <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        x0_q      <= cmd_x;
                        y0_q      <= cmd_y;
                        w_q       <= cmd_w;
                        h_q       <= cmd_h;
                        color_q   <= cmd_color;
                        mode_q    <= cmd_mode;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= StSetup;
                    end
                end

                StSetup: begin
                    if (abort || setup_empty) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        xlen_q    <= xe_clip - {1'b0, x0_q};
                        ylen_q    <= ye_clip - {1'b0, y0_q};
                        xo_q      <= '0;
                        yo_q      <= '0;
                        rowbase_q <= setup_rowbase;
                        last_q    <= 1'b0;
                        // First pixel goes out directly from SETUP.
                        oFB_WR    <= 1'b1;
                        oFB_ADDR  <= setup_rowbase;
                        oFB_DATA  <= pix(mode_q, color_q, 8'd0, 1'b0);
                        state_q   <= StWrite;
                    end
                end

                StWrite: begin
                    if (abort) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        gap_q   <= GAP_LOAD;
                        state_q <= StGap;
                        // Step to the next pixel; row wrap costs no extra cycle.
                        if ({1'b0, xo_q} + 11'd1 == xlen_q) begin
                            xo_q      <= '0;
                            yo_q      <= yo_q + 9'd1;
                            rowbase_q <= rowbase_q + STRIDE;
                            if ({1'b0, yo_q} + 10'd1 == ylen_q) begin
                                last_q <= 1'b1;
                            end
                        end else begin
                            xo_q <= xo_q + 10'd1;
                        end
                    end
                end

                StGap: begin
                    if (abort) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else if (gap_q != '0) begin
                        gap_q <= gap_q - 1'b1;
                    end else if (last_q) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        oFB_WR   <= 1'b1;
                        oFB_ADDR <= rowbase_q + 19'(xo_q);
                        oFB_DATA <= pix(mode_q, color_q, xo_q[7:0], yo_q[3]);
                        state_q  <= StWrite;
                    end
                end

                StDone: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end

                default: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_framebuffer_fill_engine.sv
module tb_vga_framebuffer_fill_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x = '0;
    logic [8:0]  cmd_y = '0;
    logic [9:0]  cmd_w = '0;
    logic [8:0]  cmd_h = '0;
    logic [7:0]  cmd_color = '0;
    logic [1:0]  cmd_mode = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        fb_wr;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;

    vga_framebuffer_fill_engine #(
        .VIDEO_W (640),
        .VIDEO_H (480),
        .WR_GAP  (2)
    ) dut (
        .iVGA_CLK  (clk),
        .iRST_n    (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .cmd_mode  (cmd_mode),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .oFB_WR    (fb_wr),
        .oFB_ADDR  (fb_addr),
        .oFB_DATA  (fb_data)
    );

    always #5 clk = ~clk;

    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    typedef struct {
        logic [18:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    typedef struct {
        int          x, y, w, h;
        logic [7:0]  c;
        logic [1:0]  m;
        int          n;
        int          d;
        bit          ab;
    } vec_t;

    wr_t        wq[$];
    int         dq[$];
    logic [7:0] mem [int];
    int         tests = 0;
    int         fails = 0;
    int         wr_count = 0;
    bit         done_seen = 1'b0;
    bit         sb_en = 1'b1;

    // Scoreboard: every write and done pulse is matched against the queued expectation.
    always @(posedge clk) begin
        #1;
        if (fb_wr) begin
            wr_count++;
            mem[int'(fb_addr)] = fb_data;
        end
        if (sb_en && rst_n) begin
            if (fb_wr) begin
                wr_t e;
                tests++;
                if (wq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: got addr=%0d data=%02h at cyc %0d, none expected",
                             fb_addr, fb_data, gcyc);
                end else begin
                    e = wq.pop_front();
                    if (fb_addr !== e.addr || fb_data !== e.data || gcyc != e.cyc) begin
                        fails++;
                        $display("FAIL write: got addr=%0d data=%02h cyc=%0d, want addr=%0d data=%02h cyc=%0d",
                                 fb_addr, fb_data, gcyc, e.addr, e.data, e.cyc);
                    end
                end
            end
            if (done) begin
                tests++;
                done_seen = 1'b1;
                if (dq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: got done at cyc %0d, none expected", gcyc);
                end else begin
                    int ec;
                    ec = dq.pop_front();
                    if (gcyc != ec || busy !== 1'b1) begin
                        fails++;
                        $display("FAIL done_timing: got cyc=%0d busy=%b, want cyc=%0d busy=1",
                                 gcyc, busy, ec);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic spot(input int a, input logic [7:0] v);
        tests++;
        if (!mem.exists(a)) begin
            fails++;
            $display("FAIL spot_%0d: got no write, want %02h", a, v);
        end else if (mem[a] !== v) begin
            fails++;
            $display("FAIL spot_%0d: got %02h, want %02h", a, mem[a], v);
        end
    endtask

    function automatic logic [7:0] model_pix(input logic [7:0] c, input logic [1:0] m,
                                             input int xo, input int yo);
        case (m)
            2'd1:    return 8'((int'(c) + xo) % 256);
            2'd2:    return (((xo / 8) % 2) != ((yo / 8) % 2)) ? ~c : c;
            default: return c;
        endcase
    endfunction

    // Expected writes of a clipped rectangle, the k-th (0-based) at edge e_edge+1+2k.
    task automatic push_model(input int x, input int y, input int w, input int h,
                              input logic [7:0] c, input logic [1:0] m,
                              input int e_edge, input int limit);
        int xe, ye, k;
        xe = (x + w > 640) ? 640 : x + w;
        ye = (y + h > 480) ? 480 : y + h;
        k = 0;
        for (int yy = y; yy < ye; yy++) begin
            for (int xx = x; xx < xe; xx++) begin
                if (k < limit) begin
                    wr_t e;
                    e.addr = 19'(yy * 640 + xx);
                    e.data = model_pix(c, m, xx - x, yy - y);
                    e.cyc  = e_edge + 1 + 2 * k;
                    wq.push_back(e);
                end
                k++;
            end
        end
    endtask

    // Called between edges (2 time units after one). exp_d is the done cycle relative to
    // the accept cycle; abort_k>0 raises abort during the abort_k-th write.
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [7:0] c, input logic [1:0] m,
                           input int exp_n, input int exp_d, input int abort_k, input bit ab);
        int e_edge, budget;
        budget = 50;
        while (!cmd_ready && budget > 0) begin
            @(posedge clk); #2;
            budget--;
        end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        mem.delete();
        wr_count  = 0;
        done_seen = 1'b0;
        e_edge    = gcyc + 1;
        push_model(x, y, w, h, c, m, e_edge, (abort_k > 0) ? abort_k : 32'h7fffffff);
        dq.push_back(e_edge - 1 + exp_d);
        cmd_x     = 10'(x);
        cmd_y     = 9'(y);
        cmd_w     = 10'(w);
        cmd_h     = 9'(h);
        cmd_color = c;
        cmd_mode  = m;
        cmd_valid = 1'b1;
        abort     = ab;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        abort = 1'b0;
        #1;
        if (abort_k > 0) begin
            repeat (2 * abort_k - 1) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
            #1;
        end
        budget = exp_d + 20;
        while (!done_seen && budget > 0) begin
            @(posedge clk); #2;
            budget--;
        end
        tests++;
        if (!done_seen) begin
            fails++;
            $display("FAIL done_timeout: got no done, want done at rel cycle %0d", exp_d);
        end
        chk("write_count", 32'(wr_count), 32'(exp_n));
        chk("pending_writes", 32'(wq.size()), 32'd0);
        wq.delete();
        dq.delete();
        @(posedge clk); #2;
        chk("ready_after_done", 32'(cmd_ready), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish before 400000 time units");
        $fatal(1, "watchdog");
    end

    vec_t vecs[9];

    initial begin
        vecs[0] = '{0,   470, 640, 480, 8'hE0, 2'd0, 6400, 12802, 1'b0}; // bottom clear to 0x4AFFF
        vecs[1] = '{0,   0,   0,   5,   8'h11, 2'd0, 0,    2,     1'b0}; // w=0
        vecs[2] = '{700, 0,   10,  10,  8'h22, 2'd0, 0,    2,     1'b0}; // x off screen
        vecs[3] = '{0,   480, 10,  10,  8'h33, 2'd0, 0,    2,     1'b0}; // y off screen
        vecs[4] = '{3,   3,   5,   0,   8'h44, 2'd0, 0,    2,     1'b0}; // h=0
        vecs[5] = '{5,   5,   3,   2,   8'h55, 2'd3, 6,    14,    1'b1}; // reserved, abort in idle
        vecs[6] = '{0,   479, 300, 5,   8'h80, 2'd1, 300,  602,   1'b0}; // gradient wrap, clip h
        vecs[7] = '{639, 478, 10,  10,  8'hAA, 2'd2, 2,    6,     1'b0}; // bottom-right corner
        vecs[8] = '{600, 100, 40,  12,  8'h3C, 2'd2, 480,  962,   1'b0}; // checker, right edge

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr", 32'(fb_wr), 32'd0);
        chk("rst_addr", 32'(fb_addr), 32'd0);
        chk("rst_data", 32'(fb_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c, vecs[i].m,
                    vecs[i].n, vecs[i].d, 0, vecs[i].ab);
        end

        // Clip at the right edge across two lines
        run_cmd(638, 10, 5, 2, 8'h1F, 2'd0, 4, 10, 0, 1'b0);
        spot(7038, 8'h1F);
        spot(7039, 8'h1F);
        spot(7678, 8'h1F);
        spot(7679, 8'h1F);

        // Checker 16x16
        run_cmd(0, 0, 16, 16, 8'h1C, 2'd2, 256, 514, 0, 1'b0);
        spot(0, 8'h1C);
        spot(8, 8'hE3);
        spot(5120, 8'hE3);
        spot(5128, 8'h1C);

        // Gradient wrap
        run_cmd(0, 0, 4, 1, 8'hFE, 2'd1, 4, 10, 0, 1'b0);
        spot(0, 8'hFE);
        spot(1, 8'hFF);
        spot(2, 8'h00);
        spot(3, 8'h01);

        // Abort during the 3rd write, then a normal command
        run_cmd(0, 20, 10, 1, 8'h33, 2'd0, 3, 7, 3, 1'b0);
        run_cmd(10, 30, 6, 2, 8'h77, 2'd0, 12, 26, 0, 1'b0);

        // Reset in the middle of a fill
        sb_en = 1'b0;
        cmd_x = 10'd0; cmd_y = 9'd100; cmd_w = 10'd100; cmd_h = 9'd10;
        cmd_color = 8'h5A; cmd_mode = 2'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_wr", 32'(fb_wr), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wq.delete();
        dq.delete();
        wr_count = 0;
        sb_en = 1'b1;
        #1;
        repeat (30) @(posedge clk);
        #2;
        chk("postrst_no_writes", 32'(wr_count), 32'd0);
        chk("postrst_busy", 32'(busy), 32'd0);
        run_cmd(1, 1, 3, 3, 8'h09, 2'd2, 9, 20, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
